conv_window_gen: RTL

Streaming sliding-window generator that sits directly upstream of the convolution MAC processing element. It accepts one multi-channel pixel per beat in raster order, inserts zero padding, and keeps K-1 padded lines plus a KxK window register. It presents each complete KxK window as one flat word, in exactly the layout the PE's `data_in` expects. Flow control on both sides is valid/ready; the PE's `pe_ready` drives `out_ready`.

---
 rtl/conv_window_gen_if.sv | 29 ++
 rtl/conv_window_gen.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel-in / window-out stream bundle of conv_window_gen.
// The window generator sits on the slave side. The master side is the
// upstream pixel source plus the downstream PE ready.
interface conv_window_gen_if #(
    parameter int pDATA_WIDTH  = 8,
    parameter int pIN_CHANNEL  = 1,
    parameter int pKERNEL_SIZE = 3
);
    localparam int PIX_W = pDATA_WIDTH * pIN_CHANNEL;
    localparam int WIN_W = PIX_W * pKERNEL_SIZE * pKERNEL_SIZE;

    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] data_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIN_W-1:0] data_out;
    logic             out_last;

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, out_last
    );

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, out_last
    );
endinterface

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming KxK sliding-window generator feeding the conv MAC PE.
// It walks a virtual zero-padded frame in raster order. It keeps K-1 padded
// lines and a KxK window register, and emits each complete window as one flat
// word. In that word, tap ky*K+kx sits at bits [tap*PIX_W +: PIX_W], with the
// top-left tap in the LSBs.
// Build option: `define CONV_WINDOW_GEN_PAD_EN compiles the zero-padding logic.
// When it is not defined, pPADDING is ignored and the frame is unpadded.
module conv_window_gen #(
    parameter int pDATA_WIDTH   = 8,
    parameter int pIN_CHANNEL   = 1,
    parameter int pINPUT_WIDTH  = 28,
    parameter int pINPUT_HEIGHT = 28,
    parameter int pKERNEL_SIZE  = 3,
    parameter int pPADDING      = 1
) (
    input  logic             clk,
    input  logic             rst,
    conv_window_gen_if.slave bus
);
    localparam int PIX_W = pDATA_WIDTH * pIN_CHANNEL;
    localparam int K     = pKERNEL_SIZE;
    localparam int WIN_W = PIX_W * K * K;
`ifdef CONV_WINDOW_GEN_PAD_EN
    localparam int PAD   = pPADDING;
`else
    // Padding parameter kept for drop-in compatibility but forced off.
    localparam int PAD   = 0 * pPADDING;
`endif
    localparam int PW    = pINPUT_WIDTH + 2 * PAD;
    localparam int PH    = pINPUT_HEIGHT + 2 * PAD;
    localparam int CW    = (PW > 1) ? $clog2(PW) : 1;
    localparam int RW    = (PH > 1) ? $clog2(PH) : 1;

    logic [CW-1:0]    vcol;
    logic [RW-1:0]    vrow;
    logic [PIX_W-1:0] line_mem [K-1][PW];
    logic [PIX_W-1:0] win      [K][K];
    logic [PIX_W-1:0] win_nxt  [K][K];
    logic [WIN_W-1:0] win_flat;
    logic [PIX_W-1:0] sample;
    logic             pad;
    logic             can_adv;
    logic             adv;
    logic             win_done;
    logic             at_col_end;
    logic             at_row_end;
    logic             out_valid_q;
    logic             out_last_q;
    logic [WIN_W-1:0] data_out_q;

    // Pad detection and sample selection at the current virtual position.
`ifdef CONV_WINDOW_GEN_PAD_EN
    assign pad = (int'(vrow) < PAD) || (int'(vrow) >= PAD + pINPUT_HEIGHT) ||
                 (int'(vcol) < PAD) || (int'(vcol) >= PAD + pINPUT_WIDTH);
    assign sample = pad ? '0 : bus.data_in;
`else
    assign pad    = 1'b0;
    assign sample = bus.data_in;
`endif

    // Flow control: a pending window blocks everything until it is taken.
    // Pad positions advance without consuming input.
    assign can_adv    = !out_valid_q || bus.out_ready;
    assign adv        = can_adv && (pad || bus.in_valid);
    assign at_col_end = (vcol == CW'(PW - 1));
    assign at_row_end = (vrow == RW'(PH - 1));
    assign win_done   = (vrow >= RW'(K - 1)) && (vcol >= CW'(K - 1));

    assign bus.in_ready  = can_adv && !pad;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.data_out  = data_out_q;

    // Next window: shift left one column. The new right column holds the
    // stored rows (oldest on top) with the fresh sample at the bottom.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign a full default
        // first, so no path leaves a value held and no latch is inferred.
        win_nxt = win;
        for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K - 1; kx++) begin
                win_nxt[ky][kx] = win[ky][kx + 1];
            end
        end
        for (int ky = 0; ky < K - 1; ky++) begin
            win_nxt[ky][K - 1] = line_mem[ky][vcol];
        end
        win_nxt[K - 1][K - 1] = sample;
    end

    // Flatten the next window into the PE word layout.
    always_comb begin
        win_flat = '0;
        for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K; kx++) begin
                win_flat[(ky * K + kx) * PIX_W +: PIX_W] = win_nxt[ky][kx];
            end
        end
    end

    // Line memories: rotate column vcol up by one row and store the new
    // sample as the newest row.
    // NOTE: line memories have no reset. Every tap is rewritten before it is
    // emitted, so clearing them would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int r = 0; r < K - 2; r++) begin
                line_mem[r][vcol] <= line_mem[r + 1][vcol];
            end
            line_mem[K - 2][vcol] <= sample;
        end
    end

    // Raster position counters and the window register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vcol <= '0;
            vrow <= '0;
            win  <= '{default: '0};
        end else if (adv) begin
            win <= win_nxt;
            if (at_col_end) begin
                vcol <= '0;
                vrow <= at_row_end ? '0 : vrow + RW'(1);
            end else begin
                vcol <= vcol + CW'(1);
            end
        end
    end

    // Output stage: a completing advance loads the window and raises valid.
    // An accept without a completing advance clears valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            data_out_q  <= '0;
        end else if (adv) begin
            out_valid_q <= win_done;
            out_last_q  <= win_done && at_col_end && at_row_end;
            if (win_done) begin
                data_out_q <= win_flat;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end
endmodule
